// File: rtl/apb4_pkg.sv
// ---------------------------------------------------------------------------
// apb4_pkg
// Shared types and helpers for the APB4 memory completer.
//   state_t     : transfer FSM states (IDLE, WAIT, DONE)
//   DEF_*       : default bus widths and memory depth
//   strb_width  : number of byte lanes for a given data width
//   idx_width   : word-index width for a given memory depth
// ---------------------------------------------------------------------------
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 64;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // A depth of one still needs a 1-bit index so the ports stay legal.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb4_mem_array.sv
// ---------------------------------------------------------------------------
// apb4_mem_array
// MEM_DEPTH x DATA_WIDTH word memory with per-byte write enables.
//   clk    in   clock, rising edge
//   rst_n  in   synchronous clear of every word while low
//   we     in   write enable
//   waddr  in   word index for the write
//   wdata  in   write data
//   wstrb  in   byte-lane enables for the write
//   raddr  in   word index for the read
//   rdata  out  combinational read of mem[raddr]
// ---------------------------------------------------------------------------
module apb4_mem_array
    import apb4_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH),
    localparam int IDX_WIDTH  = idx_width(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// ---------------------------------------------------------------------------
// apb4_mem_slave
// APB4 completer on one PSELx line of the bridge. Serves word reads and
// byte-strobed writes to an internal memory, stretches every transfer by
// WAIT_STATES access cycles and reports misaligned or out-of-range accesses
// with PSLVERR.
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   select from the bridge
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address (MSB is the bridge select bit, ignored)
//   PWDATA   in   write data
//   PSTRB    in   byte-lane write enables
//   PREADY   out  registered transfer completion, high for one cycle
//   PRDATA   out  registered read data, non-zero only in the PREADY cycle
//   PSLVERR  out  registered error flag, only in the PREADY cycle
// ---------------------------------------------------------------------------
module apb4_mem_slave
    import apb4_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter  int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter  int WAIT_STATES = 1,
    localparam int STRB_WIDTH  = strb_width(DATA_WIDTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int                   IDX_WIDTH = idx_width(MEM_DEPTH);
    localparam int                   CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(WAIT_STATES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic                  write_q;
    logic                  err_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;

    logic                  setup;
    logic [IDX_WIDTH-1:0]  bus_idx;
    logic                  bus_err;
    logic                  unused_sel_bit;
    logic [IDX_WIDTH-1:0]  fin_idx;
    logic                  fin_err;
    logic                  fin_write;
    logic                  go_done;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;

    // Decode of the live bus, used at the setup edge.
    assign setup          = PSEL && !PENABLE;
    assign bus_idx        = PADDR[IDX_WIDTH+1:2];
    assign bus_err        = (PADDR[1:0] != 2'b00) || (|PADDR[ADDR_WIDTH-2:IDX_WIDTH+2]);
    assign unused_sel_bit = PADDR[ADDR_WIDTH-1];

    // With zero wait states the transfer completes on the setup edge itself,
    // before the latched copies exist, so the live bus is used in IDLE.
    always_comb begin
        fin_idx   = idx_q;
        fin_err   = err_q;
        fin_write = write_q;
        if (state == IDLE) begin
            fin_idx   = bus_idx;
            fin_err   = bus_err;
            fin_write = PWRITE;
        end
    end

    assign go_done = ((state == IDLE) && setup && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && PSEL && PENABLE && (wait_cnt == CNT_ONE));

    // The write lands on the completing edge, i.e. the end of the PREADY cycle.
    assign mem_we = (state == DONE) && PSEL && PENABLE && PREADY && write_q && !err_q;

    apb4_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .raddr (fin_idx),
        .rdata (rd_data)
    );

    // Setup-phase capture of address and write payload (data only, no reset).
    always_ff @(posedge PCLK) begin
        if ((state == IDLE) && setup) begin
            idx_q   <= bus_idx;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // Transfer FSM, wait counter and registered response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            PREADY   <= 1'b0;
            PRDATA   <= '0;
            PSLVERR  <= 1'b0;
        end else begin
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
            if (go_done) begin
                PREADY  <= 1'b1;
                PSLVERR <= fin_err;
                PRDATA  <= (fin_err || fin_write) ? '0 : rd_data;
            end

            case (state)
                IDLE: begin
                    if (setup) begin
                        write_q  <= PWRITE;
                        err_q    <= bus_err;
                        wait_cnt <= CNT_LOAD;
                        state    <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // Losing PSEL mid-transfer abandons it without a response.
                    if (!PSEL) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (PENABLE) begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                        if (wait_cnt == CNT_ONE) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb4_mem_slave
// Three completers with 0, 1 and 3 wait states, each on its own bus, checked
// every cycle against a transaction-level model of the memory and of the
// response timing (PREADY exactly 1+WAIT_STATES cycles after setup).
// ---------------------------------------------------------------------------
module tb_apb4_mem_slave;

    localparam int N   = 3;
    localparam int WS0 = 0;
    localparam int WS1 = 1;
    localparam int WS2 = 3;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [31:0] paddr   [N];
    logic [31:0] pwdata  [N];
    logic [3:0]  pstrb   [N];
    logic        pready  [N];
    logic [31:0] prdata  [N];
    logic        pslverr [N];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          chk_en   = 1'b0;

    // Model state: expected response per bus and the memory image.
    int          exp_rdy   [N];
    logic [31:0] exp_rdata [N];
    logic        exp_err   [N];
    logic [31:0] mmem      [N][64];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb4_mem_slave #(.WAIT_STATES(WS0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb4_mem_slave #(.WAIT_STATES(WS1)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb4_mem_slave #(.WAIT_STATES(WS2)) u_dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : ((d == 1) ? WS1 : WS2);
    endfunction

    // Bit 31 selects the completer at the bridge and plays no part here.
    function automatic bit m_err(input logic [31:0] a);
        logic [31:0] off;
        off = a & 32'h7FFF_FFFF;
        return ((off % 4) != 0) || ((off / 4) >= 64);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(((a & 32'h7FFF_FFFF) / 4) % 64);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < N; d++) begin
            exp_rdy[d]   = -1;
            exp_rdata[d] = '0;
            exp_err[d]   = 1'b0;
            for (int w = 0; w < 64; w++) mmem[d][w] = '0;
        end
    endtask

    // Per-cycle comparison of every bus against the model.
    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                logic rdy;
                rdy = (cyc == exp_rdy[d]);
                chk($sformatf("pready[%0d]@%0d", d, cyc), {31'b0, pready[d]}, {31'b0, rdy});
                chk($sformatf("prdata[%0d]@%0d", d, cyc), prdata[d], rdy ? exp_rdata[d] : 32'h0);
                chk($sformatf("pslverr[%0d]@%0d", d, cyc), {31'b0, pslverr[d]},
                    {31'b0, rdy & exp_err[d]});
            end
        end
    end

    // One APB transfer on bus d. Called at posedge+1; the setup phase starts
    // immediately. mode 0: normal, 1: drop PSEL k cycles into the access
    // phase, 2: assert PRESETn k cycles into the access phase.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int mode, input int k,
                        output logic [31:0] rd, output logic er, output int lat);
        int t;
        bit e;
        int idx;
        e   = m_err(addr);
        idx = m_idx(addr);
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wd;
        pstrb[d]   = st;
        t = cyc;
        exp_err[d]   = e;
        exp_rdata[d] = (e || wr) ? 32'h0 : mmem[d][idx];
        exp_rdy[d]   = t + 1 + ws_of(d);
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        if (mode != 0) begin
            repeat (k) begin @(posedge PCLK); #1; end
            exp_rdy[d] = -1;
            if (mode == 1) begin
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
            end else begin
                PRESETn = 1'b0;
                #1;
                for (int j = 0; j < N; j++) begin
                    chk($sformatf("rst pready[%0d]", j), {31'b0, pready[j]}, 32'h0);
                    chk($sformatf("rst prdata[%0d]", j), prdata[j], 32'h0);
                    chk($sformatf("rst pslverr[%0d]", j), {31'b0, pslverr[j]}, 32'h0);
                end
                clear_model();
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
                repeat (2) begin @(posedge PCLK); #1; end
                PRESETn = 1'b1;
            end
            @(posedge PCLK); #1;
            return;
        end
        while (cyc < exp_rdy[d]) begin
            if (pready[d] && lat < 0) lat = cyc - t;
            @(posedge PCLK); #1;
        end
        if (pready[d] && lat < 0) lat = cyc - t;
        rd = prdata[d];
        er = pslverr[d];
        if (wr && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mmem[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        @(posedge PCLK); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          idx;
        int          kind;
        logic [31:0] addr;
        bit          wr;
        int          mode;

        PRESETn = 1'b0;
        for (int d = 0; d < N; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        clear_model();
        @(posedge PCLK); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge PCLK); #1; end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Full-word write and read-back, one wait state.
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
        chk("ws1 write latency", lat, 2);
        chk("ws1 write pslverr", {31'b0, er}, 32'h0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("ws1 read 0x10", rd, 32'hDEADBEEF);

        // Partial strobes merge into the existing word.
        xfer(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 0, rd, er, lat);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("strobe merge read", rd, 32'hDE22BE44);
        chk("strobe merge model", mmem[1][4], 32'hDE22BE44);

        // Out-of-range and misaligned accesses fail without touching memory.
        xfer(1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
        chk("oor pslverr", {31'b0, er}, 32'h1);
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("word0 after oor", rd, 32'h0);
        xfer(1, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
        chk("misaligned pslverr", {31'b0, er}, 32'h1);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("0x10 after misaligned", rd, 32'hDE22BE44);

        // Zero wait states, back-to-back write then read.
        xfer(0, 1'b1, 32'h4, 32'hA5A51234, 4'hF, 0, 0, rd, er, lat);
        chk("ws0 write latency", lat, 1);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("ws0 read latency", lat, 1);
        chk("ws0 read data", rd, 32'hA5A51234);

        // PSEL dropped mid-wait: no write, next transfer normal.
        xfer(2, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
        xfer(2, 1'b1, 32'h8, 32'h12345678, 4'hF, 1, 1, rd, er, lat);
        xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("abort kept old data", rd, 32'hCAFEF00D);
        xfer(2, 1'b1, 32'hC, 32'h00000055, 4'hF, 0, 0, rd, er, lat);
        chk("ws3 write latency", lat, 4);
        xfer(2, 1'b0, 32'hC, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("ws3 read data", rd, 32'h00000055);

        // Reset in the middle of a wait clears outputs and memory.
        xfer(2, 1'b1, 32'h20, 32'h99999999, 4'hF, 2, 1, rd, er, lat);
        xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("read 0x0 after reset", rd, 32'h0);
        xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("ws3 mem cleared", rd, 32'h0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("ws1 mem cleared", rd, 32'h0);

        // Randomised traffic on every bus.
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < 150; i++) begin
                kind = int'($urandom_range(0, 9));
                idx  = int'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) idx = int'($urandom_range(0, 63));
                addr = 32'(idx * 4);
                if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
                else if (kind == 1) addr = addr | (32'h100 << $urandom_range(0, 22));
                if ($urandom_range(0, 1) == 1) addr[31] = 1'b1;
                wr   = ($urandom_range(0, 1) == 1);
                mode = (d == 2 && $urandom_range(0, 9) == 0) ? 1 : 0;
                xfer(d, wr, addr, $urandom, 4'($urandom_range(0, 15)), mode,
                     int'($urandom_range(1, 2)), rd, er, lat);
                if ($urandom_range(0, 2) == 0) begin @(posedge PCLK); #1; end
            end
        end

        repeat (2) begin @(posedge PCLK); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
